// File: rtl/pipe_hazard_pkg.sv
// Shared encodings for the SimpleRisc hazard unit: EX operand forwarding selects,
// multi-cycle FSM states and the link register index written by call.
package pipe_hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MA = 2'b01;
  localparam logic [1:0] FWD_RW = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_t;

  localparam int unsigned REG_RA = 15;

endpackage

// File: rtl/pipe_hazard_unit_muldiv_stall_ctr.sv
// Multi-cycle EX occupancy tracker: IDLE/BUSY FSM plus down-counter, o_busy is registered state.
// BUSY spans MULDIV_LAT-1 cycles after the op is first seen in EX; no handshake, busy is a pure status.
module muldiv_stall_ctr
  import pipe_hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  output logic o_busy
);

  localparam int CW    = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam int LOADV = (MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0;
  localparam bit MULTI = (MULDIV_LAT > 1);

  hz_state_t     r_state;
  hz_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_drain;
  logic          w_drain_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // The finished op is still in EX for one cycle after BUSY; r_drain keeps it from re-arming.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && MULTI && !r_drain) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CW'(LOADV);
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_drain_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state == ST_BUSY);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Interlock/forwarding controller for the IF-OF-EX-MA-RW pipeline: stall/flush/bubble are combinational,
// forwarding selects register on OF->EX entry (1 cycle). HAZARD_PERF_CNT_EN adds stall/flush perf counters.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              of_valid,
  input  logic [REG_AW-1:0] of_rs1,
  input  logic [REG_AW-1:0] of_rs2,
  input  logic              of_use_rs1,
  input  logic              of_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wb,
  input  logic              ex_is_ld,
  input  logic              ex_is_muldiv,
  input  logic [REG_AW-1:0] ma_rd,
  input  logic              ma_wb,
  input  logic [REG_AW-1:0] rw_rd,
  input  logic              rw_wb,
  input  logic              br_taken,
  output logic              stall_if,
  output logic              stall_of,
  output logic              stall_ex,
  output logic              bubble_ex,
  output logic              bubble_ma,
  output logic              flush_of,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic       w_busy;
  logic       w_load_use;
  logic       w_stall_fe;
  logic       w_stall_ex;
  logic       w_bubble_ex;
  logic       w_bubble_ma;
  logic       w_flush_of;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic       w_unused_rw;

  muldiv_stall_ctr #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_muldiv (
    .clk    (clk),
    .reset_n(reset_n),
    .i_start(ex_valid & ex_is_muldiv),
    .o_busy (w_busy)
  );

  assign w_load_use = of_valid & ex_valid & ex_wb & ex_is_ld &
                      ((of_use_rs1 & (of_rs1 == ex_rd)) | (of_use_rs2 & (of_rs2 == ex_rd)));

  // BUSY > taken branch > load-use; the branch squashes the dependent op, so it never stalls.
  always_comb begin
    w_stall_fe  = 1'b0;
    w_stall_ex  = 1'b0;
    w_bubble_ex = 1'b0;
    w_bubble_ma = 1'b0;
    w_flush_of  = 1'b0;
    if (!reset_n) begin
      w_stall_fe = 1'b0;
    end else if (w_busy) begin
      w_stall_fe  = 1'b1;
      w_stall_ex  = 1'b1;
      w_bubble_ma = 1'b1;
    end else if (br_taken) begin
      w_flush_of  = 1'b1;
      w_bubble_ex = 1'b1;
    end else if (w_load_use) begin
      w_stall_fe  = 1'b1;
      w_bubble_ex = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_pick(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] e_rd,
    input logic              e_wb,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_wb
  );
    if (e_wb && (src == e_rd))      return FWD_MA;
    else if (m_wb && (src == m_rd)) return FWD_RW;
    else                            return FWD_RF;
  endfunction

  assign w_fwd_a = fwd_pick(of_rs1, ex_rd, ex_wb, ma_rd, ma_wb);
  assign w_fwd_b = fwd_pick(of_rs2, ex_rd, ex_wb, ma_rd, ma_wb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (!w_stall_ex) begin
      r_fwd_a <= w_bubble_ex ? FWD_RF : w_fwd_a;
      r_fwd_b <= w_bubble_ex ? FWD_RF : w_fwd_b;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_fe) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_of) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  // RW writes land in the regfile before OF reads it, so RW needs no forwarding path.
  assign w_unused_rw = ^{rw_rd, rw_wb};

  assign stall_if  = w_stall_fe;
  assign stall_of  = w_stall_fe;
  assign stall_ex  = w_stall_ex;
  assign bubble_ex = w_bubble_ex;
  assign bubble_ma = w_bubble_ma;
  assign flush_of  = w_flush_of;
  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed pipeline scenarios plus randomized traffic against a cycle model.
module tb_pipe_hazard_unit;

  localparam int AW  = 4;
  localparam int LAT = 4;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          of_valid, of_use_rs1, of_use_rs2;
  logic [AW-1:0] of_rs1, of_rs2;
  logic          ex_valid, ex_wb, ex_is_ld, ex_is_muldiv;
  logic [AW-1:0] ex_rd, ma_rd, rw_rd;
  logic          ma_wb, rw_wb, br_taken;
  logic          stall_if, stall_of, stall_ex, bubble_ex, bubble_ma, flush_of;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  wire [9:0] obs = {stall_if, stall_of, stall_ex, bubble_ex, bubble_ma, flush_of, fwd_a_sel, fwd_b_sel};

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: remaining BUSY cycles, drain cycle flag, expected selects and counts
  int          m_busy_rem;
  bit          m_guard;
  logic [1:0]  m_fa, m_fb;
  logic [31:0] m_stalls, m_flushes;
  bit          e_sif, e_sex, e_bex, e_bma, e_flush;
  logic [9:0]  e_v;

  pipe_hazard_unit #(.REG_AW(AW), .MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2), .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_is_ld(ex_is_ld), .ex_is_muldiv(ex_is_muldiv),
    .ma_rd(ma_rd), .ma_wb(ma_wb), .rw_rd(rw_rd), .rw_wb(rw_wb), .br_taken(br_taken),
    .stall_if(stall_if), .stall_of(stall_of), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .bubble_ma(bubble_ma), .flush_of(flush_of), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_of(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic u1, input logic u2);
    of_valid = v; of_rs1 = r1; of_rs2 = r2; of_use_rs1 = u1; of_use_rs2 = u2;
  endtask

  task automatic set_ex(input logic v, input logic [AW-1:0] rd, input logic wb,
                        input logic ld, input logic md, input logic br);
    ex_valid = v; ex_rd = rd; ex_wb = wb; ex_is_ld = ld; ex_is_muldiv = md; br_taken = br;
  endtask

  task automatic set_ma(input logic [AW-1:0] rd, input logic wb);
    ma_rd = rd; ma_wb = wb;
  endtask

  task automatic idle_inputs();
    set_of(0, '0, '0, 0, 0); set_ex(0, '0, 0, 0, 0, 0); set_ma('0, 0);
    rw_rd = '0; rw_wb = 1'b0;
  endtask

  task automatic cyc_end();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_busy_rem = 0; m_guard = 0; m_fa = 2'd0; m_fb = 2'd0; m_stalls = 0; m_flushes = 0;
  endtask

  function automatic logic [1:0] pick(input logic [AW-1:0] src);
    if (ex_wb && src == ex_rd) return 2'd1;
    if (ma_wb && src == ma_rd) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_eval();
    bit lu;
    lu = of_valid && ex_valid && ex_wb && ex_is_ld &&
         ((of_use_rs1 && of_rs1 == ex_rd) || (of_use_rs2 && of_rs2 == ex_rd));
    e_sif = 0; e_sex = 0; e_bex = 0; e_bma = 0; e_flush = 0;
    if (m_busy_rem > 0) begin
      e_sif = 1; e_sex = 1; e_bma = 1;
    end else if (br_taken) begin
      e_flush = 1; e_bex = 1;
    end else if (lu) begin
      e_sif = 1; e_bex = 1;
    end
    e_v = {e_sif, e_sif, e_sex, e_bex, e_bma, e_flush, m_fa, m_fb};
  endtask

  task automatic model_update();
    if (!e_sex) begin
      m_fa = e_bex ? 2'd0 : pick(of_rs1);
      m_fb = e_bex ? 2'd0 : pick(of_rs2);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (e_sif)   m_stalls  = m_stalls + 1;
    if (e_flush) m_flushes = m_flushes + 1;
`endif
    if (m_busy_rem > 0) begin
      m_busy_rem = m_busy_rem - 1;
      if (m_busy_rem == 0) m_guard = 1;
    end else if (m_guard) begin
      m_guard = 0;
    end else if (ex_valid && ex_is_muldiv && LAT > 1) begin
      m_busy_rem = LAT - 1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_of(1, 4'd1, 4'd1, 1, 1); set_ex(1, 4'd1, 1, 1, 0, 1); set_ma(4'd1, 1);
    rw_rd = 4'd1; rw_wb = 1'b1;
    #3;
    n_checks++;
    if ({obs, stall_cnt, flush_cnt} !== '0) begin
      n_fails++;
      $display("FAIL reset_async got ctl=%b stall_cnt=%0d flush_cnt=%0d exp all 0", obs, stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({obs, stall_cnt, flush_cnt} !== '0) begin
      n_fails++;
      $display("FAIL reset_held got ctl=%b stall_cnt=%0d flush_cnt=%0d exp all 0", obs, stall_cnt, flush_cnt);
    end
    do_reset();
  endtask

  task automatic test_fwd_ex();
    logic [9:0] exp_v [4];
    exp_v[0] = 10'b0000000000; exp_v[1] = 10'b0000000100;
    exp_v[2] = 10'b0000001001; exp_v[3] = 10'b0000000100;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin set_ex(1, 4'd1, 1, 0, 0, 0); set_of(1, 4'd1, 4'd5, 1, 1); set_ma(4'd0, 0); end
        1: begin set_ex(1, 4'd4, 1, 0, 0, 0); set_ma(4'd1, 1); set_of(1, 4'd1, 4'd4, 1, 1); end
        2: begin set_ex(1, 4'd7, 1, 0, 0, 0); set_ma(4'd7, 1); set_of(1, 4'd7, 4'd0, 1, 1); end
        default: begin set_ex(0, 4'd0, 0, 0, 0, 0); set_ma(4'd0, 0); set_of(0, 4'd0, 4'd0, 0, 0); end
      endcase
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v[c]) begin
        n_fails++;
        $display("FAIL fwd_ex cyc%0d got=%b exp=%b", c, obs, exp_v[c]);
      end
      cyc_end();
    end
  endtask

  task automatic test_ld_use(input bit rst);
    logic [9:0] exp_v [3];
    exp_v[0] = 10'b1101000000; exp_v[1] = 10'b0000000000; exp_v[2] = 10'b0000001010;
    if (rst) do_reset();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin set_ex(1, 4'd1, 1, 1, 0, 0); set_of(1, 4'd1, 4'd1, 1, 1); set_ma(4'd0, 0); end
        1: begin set_ex(0, 4'd0, 0, 0, 0, 0); set_ma(4'd1, 1); end
        default: begin set_ex(1, 4'd3, 1, 0, 0, 0); set_ma(4'd0, 0); set_of(0, 4'd0, 4'd0, 0, 0); end
      endcase
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v[c]) begin
        n_fails++;
        $display("FAIL ld_use cyc%0d got=%b exp=%b", c, obs, exp_v[c]);
      end
      cyc_end();
    end
  endtask

  task automatic test_br_over_ld(input bit rst);
    if (rst) do_reset();
    set_ex(1, 4'd1, 1, 1, 0, 1); set_of(1, 4'd1, 4'd1, 1, 1); set_ma(4'd0, 0);
    @(negedge clk);
    n_checks++;
    if (obs !== 10'b0001010000) begin
      n_fails++;
      $display("FAIL br_over_ld taken got=%b exp=%b", obs, 10'b0001010000);
    end
    cyc_end();
    set_ex(0, 4'd0, 0, 0, 0, 0); set_of(0, 4'd0, 4'd0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (obs !== 10'b0000000000) begin
      n_fails++;
      $display("FAIL br_over_ld after got=%b exp=%b", obs, 10'b0000000000);
    end
    cyc_end();
  endtask

  task automatic test_muldiv();
    logic [9:0] ev;
    int n_sex, n_bma;
    n_sex = 0; n_bma = 0;
    do_reset();
    set_ex(1, 4'd1, 1, 0, 1, 0); set_of(1, 4'd1, 4'd7, 1, 1); set_ma(4'd0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ev = (c >= 1 && c <= 3) ? 10'b1110100100 : ((c == 0) ? 10'b0000000000 : 10'b0000000100);
      n_sex += int'(stall_ex); n_bma += int'(bubble_ma);
      n_checks++;
      if (obs !== ev) begin
        n_fails++;
        $display("FAIL muldiv cyc%0d got=%b exp=%b", c, obs, ev);
      end
      cyc_end();
    end
    set_ma(4'd1, 1); set_ex(1, 4'd6, 1, 0, 0, 0); set_of(1, 4'd2, 4'd3, 1, 1);
    @(negedge clk);
    n_sex += int'(stall_ex); n_bma += int'(bubble_ma);
    n_checks++;
    if (obs !== 10'b0000000100) begin
      n_fails++;
      $display("FAIL muldiv consumer got=%b exp=%b", obs, 10'b0000000100);
    end
    n_checks++;
    if (n_sex != 3 || n_bma != 3) begin
      n_fails++;
      $display("FAIL muldiv occupancy stall_ex=%0d bubble_ma=%0d cycles, exp 3 and 3", n_sex, n_bma);
    end
    cyc_end();
  endtask

  task automatic test_reset_busy();
    do_reset();
    set_ex(1, 4'd2, 1, 0, 1, 0); set_of(1, 4'd9, 4'd10, 0, 0); set_ma(4'd0, 0);
    @(negedge clk);
    n_checks++;
    if (obs !== 10'b0000000000) begin
      n_fails++;
      $display("FAIL rst_busy issue got=%b exp=%b", obs, 10'b0000000000);
    end
    cyc_end();
    @(negedge clk);
    n_checks++;
    if (obs !== 10'b1110100000) begin
      n_fails++;
      $display("FAIL rst_busy busy1 got=%b exp=%b", obs, 10'b1110100000);
    end
    cyc_end();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({obs, stall_cnt, flush_cnt} !== '0) begin
      n_fails++;
      $display("FAIL rst_busy async got ctl=%b stall_cnt=%0d flush_cnt=%0d exp all 0", obs, stall_cnt, flush_cnt);
    end
    cyc_end();
    idle_inputs();
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 10'b0000000000) begin
        n_fails++;
        $display("FAIL rst_busy release cyc%0d got=%b exp=%b", c, obs, 10'b0000000000);
      end
      cyc_end();
    end
  endtask

  task automatic test_perf();
    logic [CW-1:0] es, ef;
`ifdef HAZARD_PERF_CNT_EN
    es = 1; ef = 1;
`else
    es = 0; ef = 0;
`endif
    do_reset();
    test_ld_use(0);
    test_br_over_ld(0);
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== es) begin
      n_fails++;
      $display("FAIL perf stall_cnt got=%0d exp=%0d", stall_cnt, es);
    end
    n_checks++;
    if (flush_cnt !== ef) begin
      n_fails++;
      $display("FAIL perf flush_cnt got=%0d exp=%0d", flush_cnt, ef);
    end
    cyc_end();
  endtask

  task automatic rand_inputs();
    int r;
    set_of($urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
    set_ma(AW'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
    rw_rd = AW'($urandom_range(0, 15)); rw_wb = ($urandom_range(0, 1) != 0);
    if (m_busy_rem == 0 && !m_guard) begin
      r = $urandom_range(0, 7);
      ex_valid     = ($urandom_range(0, 4) != 0);
      ex_rd        = AW'($urandom_range(0, 3));
      ex_wb        = ($urandom_range(0, 1) != 0);
      ex_is_muldiv = ex_valid && (r == 0);
      ex_is_ld     = ex_valid && (r == 1 || r == 2);
      br_taken     = ex_valid && !ex_is_muldiv && !ex_is_ld && ($urandom_range(0, 2) == 0);
    end else begin
      br_taken = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [CW-1:0] es, ef;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      @(negedge clk);
      model_eval();
      es = m_stalls; ef = m_flushes;
      n_checks++;
      if (obs !== e_v) begin
        n_fails++;
        $display("FAIL rand_ctl cyc%0d got=%b exp=%b", i, obs, e_v);
      end
      n_checks++;
      if (stall_cnt !== es || flush_cnt !== ef) begin
        n_fails++;
        $display("FAIL rand_cnt cyc%0d got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                 i, stall_cnt, flush_cnt, es, ef);
      end
      model_update();
      cyc_end();
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_ld_use(1);
    test_br_over_ld(1);
    test_muldiv();
    test_reset_busy();
    test_perf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
